inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction fetch unit: producer side of the instruction stream that the decoder consumes.
//  Generates sequential PCs, fetches 32-bit words from instruction memory (valid/ready request and response),
//  and buffers {inst, pc, fault} in a small FIFO. Presents entries to decode via a valid/ready handshake.
//  Branch/jump redirects from execute flush the FIFO and restart fetch at a new PC.
// PARAMETERS
//  RESET_PC    32'h8000_0000  first fetch address after reset
//  FIFO_DEPTH  2              instruction buffer entries (power of 2, >=2)
// PORTS
//  clk_i             in   1   clock, rising edge
//  rst_i             in   1   reset, asynchronous, active-high
//  redirect_valid_i  in   1   pulse: restart fetch at redirect_pc_i
//  redirect_pc_i     in   32  new PC; bits [1:0] ignored (forced 2'b00)
//  imem_req_valid_o  out  1   fetch request valid
//  imem_req_ready_i  in   1   memory accepts request
//  imem_req_addr_o   out  32  word-aligned fetch address
//  imem_rsp_valid_i  in   1   response valid; always accepted, no ready
//  imem_rsp_data_i   in   32  fetched instruction word
//  imem_rsp_err_i    in   1   access fault for this response
//  inst_valid_o      out  1   FIFO head valid toward decode
//  inst_ready_i      in   1   decode consumes head
//  inst_o            out  32  instruction word (decoder inst_i)
//  inst_pc_o         out  32  PC of inst_o
//  inst_fault_o      out  1   fetch fault for inst_o
// BEHAVIOUR
//  Reset (async, active-high): fetch_pc=RESET_PC, state=REQ, FIFO empty, stale=0.
//   Outputs: imem_req_valid_o=0, imem_req_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0, inst_fault_o=0.
//  At most one outstanding request. Request handshake = req_valid & req_ready.
//  FSM:
//   REQ:  assert req_valid when fifo_count + 0 < FIFO_DEPTH; addr=fetch_pc.
//         On handshake: fetch_pc+=4 (mod 2^32, wraps), req_pc<=addr, go WAIT (DROP if stale|redirect).
//   WAIT: on rsp_valid: push {data, req_pc, err}, go REQ.
//   DROP: on rsp_valid: discard response, go REQ.
//  Once asserted, req_valid and addr hold stable until accepted; a redirect never withdraws an unaccepted request.
//  Redirect while an unaccepted request is presented: set stale. The old address is still issued; its
//   response is dropped. stale clears on acceptance.
//  Redirect effect (registered, next cycle): FIFO flushed, fetch_pc=redirect_pc_i&~3.
//   In WAIT without rsp same cycle -> DROP. In WAIT with rsp same cycle -> rsp discarded, go REQ.
//   In DROP -> stays DROP.
//  Simultaneous redirect + pop: flush wins, pop ignored. Redirect + push: push discarded.
//   Back-to-back redirects: last one wins.
//  FIFO: push and pop in the same cycle are both legal when full (pop frees the slot first).
//   inst_valid_o = !empty. inst_o/inst_pc_o/inst_fault_o = head entry, stable while valid & !ready.
//  Latency: request accepted cycle N, response cycle N+k (k>=1), inst_valid_o high at N+k+1.
//  Fault: err response is pushed with fault=1 and data as returned. Sequential fetch continues;
//   decode/exception logic owns handling.
//  Responses arriving in REQ are a protocol violation; the bench asserts they never occur.
// STRUCTURE
//  Shared package rv_pkg: RESET_PC default, XLEN=32, INST_NOP=32'h0000_0013, fetch state encoding
//   (REQ/WAIT/DROP), fetch entry struct {inst[31:0], pc[31:0], fault}.
//  One sub-module: inst_fifo (sync FIFO, width 65, depth FIFO_DEPTH, flush input, full/empty/count).
//  Top: FSM, fetch_pc/req_pc/stale registers, handshake glue.
// TESTING
//  1. Reset release, memory always ready, 1-cycle rsp, decode always ready: requests at 8000_0000, _0004, _0008.
//     Insts appear in order, inst_pc_o matches, one inst per 2 cycles.
//  2. Decode ready=0 for 10 cycles: FIFO fills to 2, req_valid drops.
//     Ready=1 -> entries 8000_0000/_0004 drained in order, fetch resumes at 8000_0008.
//  3. Redirect to 8000_0100 while WAIT for 8000_0004 (rsp 3 cycles later):
//     that rsp dropped, FIFO empty next cycle, next request addr=8000_0100.
//  4. Redirect to 8000_0200 while req_valid=1, ready=0 at 8000_0008:
//     addr stays 8000_0008 until accepted, rsp discarded, then request 8000_0200.
//  5. rsp_err=1 on 8000_0004: entry has fault=1, pc=8000_0004, then 8000_0008 fetched.
//  6. Assert rst_i mid-WAIT with FIFO holding 1: outputs zero immediately, first request after release = RESET_PC.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared front-end types: XLEN, reset/NOP constants, fetch FSM states and the
// buffered fetch entry that travels from instruction memory to decode.
package rv_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_DROP
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO for fetched instructions; flush empties it in one cycle.
// The caller never pushes into a full FIFO without a pop, nor pops when empty.
module inst_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // Empty reads return zero so the decode-side outputs are clean without resetting storage.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage has no reset; validity lives entirely in the pointers and count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: sequential PC generation, one outstanding imem request,
// and a small instruction buffer toward decode that redirects flush.
module inst_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_fault_o
);

  localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_next;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_addr;
  logic            req_valid;
  logic            stale;
  logic            handshake;
  logic            hold;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   count_next;
  logic            space_next;
  fetch_entry_t    wr_entry;
  fetch_entry_t    rd_entry;

  assign handshake  = req_valid && imem_req_ready_i;
  assign hold       = req_valid && !imem_req_ready_i;
  // A redirect flushes the buffer, so it overrides both the pop and the push of that cycle.
  assign pop        = !fifo_empty && inst_ready_i && !redirect_valid_i;
  assign push       = (state == FETCH_WAIT) && imem_rsp_valid_i && !redirect_valid_i &&
                      (!fifo_full || pop);
  assign count_next = redirect_valid_i ? '0 : fifo_count + CW'(push) - CW'(pop);
  assign space_next = (count_next < DEPTH_C);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    fetch_pc_next = fetch_pc;
    if (redirect_valid_i)        fetch_pc_next = align_word(redirect_pc_i);
    else if (handshake && !stale) fetch_pc_next = fetch_pc + XLEN'(4);
  end

  always_comb begin
    wr_entry.inst  = imem_rsp_data_i;
    wr_entry.pc    = req_pc;
    wr_entry.fault = imem_rsp_err_i;
  end

  // A stale request carries a pre-redirect address: it is issued but its response is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= FETCH_REQ;
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      req_addr  <= RESET_PC;
      req_valid <= 1'b0;
      stale     <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_next;
      if (!hold) req_addr <= fetch_pc_next;
      if (handshake)                    stale <= 1'b0;
      else if (hold && redirect_valid_i) stale <= 1'b1;

      unique case (state)
        FETCH_REQ: begin
          if (handshake) begin
            req_pc    <= req_addr;
            req_valid <= 1'b0;
            state     <= (stale || redirect_valid_i) ? FETCH_DROP : FETCH_WAIT;
          end else if (!hold) begin
            req_valid <= space_next;
          end
        end
        FETCH_WAIT: begin
          if (imem_rsp_valid_i) begin
            state     <= FETCH_REQ;
            req_valid <= space_next;
          end else if (redirect_valid_i) begin
            state <= FETCH_DROP;
          end
        end
        FETCH_DROP: begin
          if (imem_rsp_valid_i) begin
            state     <= FETCH_REQ;
            req_valid <= space_next;
          end
        end
        default: begin
          state     <= FETCH_REQ;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

  inst_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (redirect_valid_i),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = req_addr;
  assign inst_valid_o     = !fifo_empty;
  assign inst_o           = rd_entry.inst;
  assign inst_pc_o        = rd_entry.pc;
  assign inst_fault_o     = rd_entry.fault;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: memory responder, stream model of what decode must see,
// and directed scenarios with hand-computed request/pop timing.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int          checks = 0;
  int          errors = 0;
  string       tname  = "init";
  int          cur    = 0;

  int unsigned lat      = 1;
  logic        err_en   = 1'b0;
  logic [31:0] err_addr = '0;

  logic [31:0] hs_addr[$];
  int          hs_cyc[$];
  logic [31:0] pop_pc[$];
  int          pop_cyc[$];

  inst_fetch dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .redirect_valid_i (redirect),
    .redirect_pc_i    (redirect_pc),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .imem_rsp_err_i   (rsp_err),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (inst_ready),
    .inst_o           (inst),
    .inst_pc_o        (inst_pc),
    .inst_fault_o     (inst_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h", tname, name, act, exp);
    end
  endtask

  // Instruction memory: accepts requests, answers each after 'lat' cycles.
  initial begin
    bit          pend;
    int          cnt;
    logic [31:0] pend_addr;
    pend = 0; cnt = 0; pend_addr = '0;
    rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) pend = 0;
      else if (req_valid && req_ready) begin
        check("one_outstanding", 32'(pend), 32'd0);
        pend = 1; pend_addr = addr; cnt = int'(lat);
      end
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      if (pend && !rst) begin
        cnt--;
        if (cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_data  = word_at(pend_addr);
          rsp_err   = err_en && (pend_addr == err_addr);
          pend      = 0;
        end
      end
    end
  end

  // Stream model: decode must see consecutive words from the last reset/redirect target.
  initial begin
    logic [31:0] exp_pc;
    exp_pc = RESET_PC;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc = RESET_PC;
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
      end else begin
        if (req_valid) check("req_aligned", {30'b0, addr[1:0]}, 32'd0);
        if (inst_valid) begin
          check("stream_pc", inst_pc, exp_pc);
          check("stream_inst", inst, word_at(exp_pc));
          check("stream_fault", 32'(inst_fault), 32'(err_en && exp_pc == err_addr));
        end
        if (redirect)                     exp_pc = redirect_pc & ~32'h3;
        else if (inst_valid && inst_ready) exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic run_to(input int c);
    while (cur < c) begin
      if (req_valid && req_ready) begin
        hs_addr.push_back(addr);
        hs_cyc.push_back(cur);
      end
      if (inst_valid && inst_ready && !redirect) begin
        pop_pc.push_back(inst_pc);
        pop_cyc.push_back(cur);
      end
      @(posedge clk); #2;
      cur++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    req_ready = 1'b1; inst_ready = 1'b1; lat = 1; err_en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    cur = 0;
    hs_addr.delete(); hs_cyc.delete(); pop_pc.delete(); pop_cyc.delete();
  endtask

  task automatic chk_hs(input int i, input logic [31:0] a, input int c);
    if (i < hs_addr.size()) begin
      check($sformatf("req%0d_addr", i), hs_addr[i], a);
      check($sformatf("req%0d_cycle", i), 32'(hs_cyc[i]), 32'(c));
    end else check($sformatf("req%0d_count", i), 32'(hs_addr.size()), 32'(i + 1));
  endtask

  task automatic chk_pop(input int i, input logic [31:0] pc, input int c);
    if (i < pop_pc.size()) begin
      check($sformatf("pop%0d_pc", i), pop_pc[i], pc);
      check($sformatf("pop%0d_cycle", i), 32'(pop_cyc[i]), 32'(c));
    end else check($sformatf("pop%0d_count", i), 32'(pop_pc.size()), 32'(i + 1));
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; req_ready = 1'b1; inst_ready = 1'b1;
    #12;
    tname = "reset";
    check("req_valid", 32'(req_valid), 32'd0);
    check("req_addr", addr, RESET_PC);
    check("inst_valid", 32'(inst_valid), 32'd0);
    check("inst", inst, 32'd0);
    check("inst_pc", inst_pc, 32'd0);
    check("inst_fault", 32'(inst_fault), 32'd0);

    tname = "t1_stream";
    do_reset();
    run_to(12);
    chk_hs(0, 32'h8000_0000, 1);
    chk_hs(1, 32'h8000_0004, 3);
    chk_hs(2, 32'h8000_0008, 5);
    chk_pop(0, 32'h8000_0000, 3);
    chk_pop(1, 32'h8000_0004, 5);
    chk_pop(2, 32'h8000_0008, 7);

    tname = "t2_backpressure";
    do_reset();
    inst_ready = 1'b0;
    run_to(10);
    check("full_valid", 32'(inst_valid), 32'd1);
    check("full_head_pc", inst_pc, 32'h8000_0000);
    check("full_req_valid", 32'(req_valid), 32'd0);
    check("full_req_count", 32'(hs_addr.size()), 32'd2);
    inst_ready = 1'b1;
    run_to(14);
    chk_pop(0, 32'h8000_0000, 10);
    chk_pop(1, 32'h8000_0004, 11);
    chk_hs(2, 32'h8000_0008, 11);
    chk_pop(2, 32'h8000_0008, 13);

    tname = "t3_redirect_wait";
    do_reset();
    inst_ready = 1'b0;
    run_to(2);
    lat = 3;
    run_to(4);
    check("pre_inst_valid", 32'(inst_valid), 32'd1);
    check("pre_req_valid", 32'(req_valid), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h8000_0100;
    run_to(5);
    redirect = 1'b0; lat = 1;
    check("flushed", 32'(inst_valid), 32'd0);
    run_to(6);
    check("drop_req_valid", 32'(req_valid), 32'd0);
    run_to(7);
    check("new_req_valid", 32'(req_valid), 32'd1);
    check("new_req_addr", addr, 32'h8000_0100);
    check("no_stale_inst", 32'(inst_valid), 32'd0);
    inst_ready = 1'b1;
    run_to(10);
    chk_hs(2, 32'h8000_0100, 7);
    chk_pop(0, 32'h8000_0100, 9);

    tname = "t4_redirect_stalled_req";
    do_reset();
    run_to(5);
    req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h8000_0202;
    check("held_valid5", 32'(req_valid), 32'd1);
    check("held_addr5", addr, 32'h8000_0008);
    run_to(6);
    redirect = 1'b0;
    check("held_valid6", 32'(req_valid), 32'd1);
    check("held_addr6", addr, 32'h8000_0008);
    run_to(8);
    check("held_addr8", addr, 32'h8000_0008);
    req_ready = 1'b1;
    run_to(9);
    check("drop_req_valid", 32'(req_valid), 32'd0);
    run_to(10);
    check("new_req_valid", 32'(req_valid), 32'd1);
    check("new_req_addr", addr, 32'h8000_0200);
    check("no_stale_inst", 32'(inst_valid), 32'd0);
    run_to(13);
    chk_hs(2, 32'h8000_0008, 8);
    chk_pop(1, 32'h8000_0200, 12);
    check("pop_count", 32'(pop_pc.size()), 32'd2);

    tname = "t5_fault";
    do_reset();
    err_en = 1'b1; err_addr = 32'h8000_0004;
    run_to(5);
    check("fault_valid", 32'(inst_valid), 32'd1);
    check("fault_pc", inst_pc, 32'h8000_0004);
    check("fault_bit", 32'(inst_fault), 32'd1);
    check("fault_data", inst, 32'hFFFB_0004);
    run_to(7);
    check("next_pc", inst_pc, 32'h8000_0008);
    check("next_fault", 32'(inst_fault), 32'd0);
    check("next_data", inst, 32'hFFF7_0008);
    err_en = 1'b0;

    tname = "t6_reset_mid_wait";
    do_reset();
    inst_ready = 1'b0;
    run_to(2);
    lat = 3;
    run_to(4);
    check("pre_inst_valid", 32'(inst_valid), 32'd1);
    check("pre_req_valid", 32'(req_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_req_addr", addr, RESET_PC);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_fault", 32'(inst_fault), 32'd0);
    do_reset();
    run_to(4);
    chk_hs(0, RESET_PC, 1);
    chk_pop(0, RESET_PC, 3);

    tname = "t7_wrap_back_to_back";
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h1000_0000;
    run_to(1);
    redirect_pc = 32'hFFFF_FFF8;
    run_to(2);
    redirect = 1'b0;
    run_to(10);
    chk_hs(0, 32'h1000_0000, 1);
    chk_hs(1, 32'hFFFF_FFF8, 3);
    chk_hs(2, 32'hFFFF_FFFC, 5);
    chk_hs(3, 32'h0000_0000, 7);
    chk_pop(0, 32'hFFFF_FFF8, 5);
    chk_pop(1, 32'hFFFF_FFFC, 7);
    chk_pop(2, 32'h0000_0000, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
